// File: rtl/sram_march_if.sv
// Shared bus between the March C- test engine and its host/SRAM side.
// The inject line exists only when SRAM_MARCH_FAULT_INJECT_EN is defined.
interface sram_march_if #(
   parameter int unsigned NUM_BANKS = 2,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned DATA_W    = 32
) ();
   logic                          start;
   logic                          busy;
   logic                          done;
   logic                          pass;
   logic [NUM_BANKS-1:0]          fail_mask;
   logic [ADDR_W-1:0]             fail_addr;
   logic                          mem_men;
   logic                          mem_wen;
   logic                          mem_ren;
   logic [ADDR_W-1:0]             mem_addr;
   logic [DATA_W-1:0]             mem_din;
   logic [DATA_W-1:0]             mem_bm;
   logic [NUM_BANKS*DATA_W-1:0]   mem_dout;
`ifdef SRAM_MARCH_FAULT_INJECT_EN
   logic                          inject;
`endif

   modport master (
      input  start, mem_dout,
`ifdef SRAM_MARCH_FAULT_INJECT_EN
      input  inject,
`endif
      output busy, done, pass, fail_mask, fail_addr,
      output mem_men, mem_wen, mem_ren, mem_addr, mem_din, mem_bm
   );

   modport slave (
      output start, mem_dout,
`ifdef SRAM_MARCH_FAULT_INJECT_EN
      output inject,
`endif
      input  busy, done, pass, fail_mask, fail_addr,
      input  mem_men, mem_wen, mem_ren, mem_addr, mem_din, mem_bm
   );
endinterface

// File: rtl/sram_march_tester.sv
// March C- engine testing NUM_BANKS SRAMs in parallel over one shared command bus.
// Optional SRAM_MARCH_FAULT_INJECT_EN: inject flips bit 0 of every write to address 0.
module sram_march_tester #(
   parameter int unsigned NUM_BANKS  = 2,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned DATA_W     = 32,
   parameter logic [31:0] BG_PATTERN = 32'h5555_5555
) (
   input  logic         clk,
   input  logic         rst,
   sram_march_if.master bus
);
   localparam logic [DATA_W-1:0] P        = DATA_W'(BG_PATTERN);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   typedef enum logic [3:0] {
      S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
   } state_t;

   state_t               r_state, w_nxt_state;
   logic [ADDR_W-1:0]    r_addr, w_nxt_addr;
   logic                 r_rd, w_nxt_rd;
   logic                 r_men, r_wen, r_ren;
   logic [DATA_W-1:0]    r_din, r_exp;
   logic                 r_cmp_vld;
   logic [DATA_W-1:0]    r_cmp_exp;
   logic [ADDR_W-1:0]    r_cmp_addr;
   logic                 r_busy, r_done, r_pass;
   logic [NUM_BANKS-1:0] r_fail_mask;
   logic [ADDR_W-1:0]    r_fail_addr;
   logic                 w_cmd_rd, w_cmd_wr, w_inj;
   logic [DATA_W-1:0]    w_wdata, w_cmd_din, w_cmd_exp;
   logic [NUM_BANKS-1:0] w_mis;
   logic                 w_last_up, w_last_dn;

`ifdef SRAM_MARCH_FAULT_INJECT_EN
   logic r_inject;
   // Inject is sampled live on the start edge because the first write is commanded then.
   assign w_inj = (r_state == S_IDLE) ? bus.inject : r_inject;
`else
   assign w_inj = 1'b0;
`endif

   assign w_last_up = (r_addr == ADDR_MAX);
   assign w_last_dn = (r_addr == '0);

   // Sequencing: r_state/r_addr/r_rd describe the command currently on the bus.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_addr  = r_addr;
      w_nxt_rd    = r_rd;
      case (r_state)
         S_IDLE: if (bus.start) begin
            w_nxt_state = S_M0;
            w_nxt_addr  = '0;
            w_nxt_rd    = 1'b0;
         end
         S_M0: if (w_last_up) begin
            w_nxt_state = S_M1;
            w_nxt_addr  = '0;
            w_nxt_rd    = 1'b1;
         end else begin
            w_nxt_addr = r_addr + ADDR_W'(1);
         end
         S_M1, S_M2: if (r_rd) begin
            w_nxt_rd = 1'b0;
         end else begin
            w_nxt_rd = 1'b1;
            if (!w_last_up) begin
               w_nxt_addr = r_addr + ADDR_W'(1);
            end else if (r_state == S_M1) begin
               w_nxt_state = S_M2;
               w_nxt_addr  = '0;
            end else begin
               w_nxt_state = S_M3;
               w_nxt_addr  = ADDR_MAX;
            end
         end
         S_M3, S_M4: if (r_rd) begin
            w_nxt_rd = 1'b0;
         end else begin
            w_nxt_rd   = 1'b1;
            w_nxt_addr = r_addr - ADDR_W'(1);
            if (w_last_dn) begin
               w_nxt_addr  = ADDR_MAX;
               w_nxt_state = (r_state == S_M3) ? S_M4 : S_M5;
            end
         end
         S_M5: if (w_last_dn) begin
            w_nxt_state = S_DRAIN;
            w_nxt_addr  = '0;
            w_nxt_rd    = 1'b0;
         end else begin
            w_nxt_addr = r_addr - ADDR_W'(1);
         end
         S_DRAIN: w_nxt_state = S_DONE;
         S_DONE:  w_nxt_state = S_IDLE;
         default: w_nxt_state = S_IDLE;
      endcase
   end

   // Command for the next cycle, derived from the next sequencing position.
   always_comb begin
      w_cmd_rd  = 1'b0;
      w_cmd_wr  = 1'b0;
      w_wdata   = '0;
      w_cmd_exp = '0;
      case (w_nxt_state)
         S_M0: begin
            w_cmd_wr = 1'b1;
            w_wdata  = P;
         end
         S_M1, S_M3: begin
            w_cmd_rd  = w_nxt_rd;
            w_cmd_wr  = !w_nxt_rd;
            w_cmd_exp = P;
            w_wdata   = ~P;
         end
         S_M2, S_M4: begin
            w_cmd_rd  = w_nxt_rd;
            w_cmd_wr  = !w_nxt_rd;
            w_cmd_exp = ~P;
            w_wdata   = P;
         end
         S_M5: begin
            w_cmd_rd  = 1'b1;
            w_cmd_exp = P;
         end
         default: ;
      endcase
      w_cmd_din = w_cmd_wr ? (w_wdata ^ DATA_W'(w_inj && (w_nxt_addr == '0))) : '0;
   end

   always_comb begin
      w_mis = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         w_mis[b] = r_cmp_vld && (bus.mem_dout[b*DATA_W +: DATA_W] != r_cmp_exp);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_rd        <= 1'b0;
         r_men       <= 1'b0;
         r_wen       <= 1'b0;
         r_ren       <= 1'b0;
         r_din       <= '0;
         r_exp       <= '0;
         r_cmp_vld   <= 1'b0;
         r_cmp_exp   <= '0;
         r_cmp_addr  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_mask <= '0;
         r_fail_addr <= '0;
`ifdef SRAM_MARCH_FAULT_INJECT_EN
         r_inject    <= 1'b0;
`endif
      end else begin
         r_state    <= w_nxt_state;
         r_addr     <= w_nxt_addr;
         r_rd       <= w_nxt_rd;
         r_men      <= w_cmd_rd | w_cmd_wr;
         r_wen      <= w_cmd_wr;
         r_ren      <= w_cmd_rd;
         r_din      <= w_cmd_din;
         r_exp      <= w_cmd_exp;
         // Read data returns one cycle after the issuing edge.
         r_cmp_vld  <= r_ren;
         r_cmp_exp  <= r_exp;
         r_cmp_addr <= r_addr;
         r_done     <= (r_state == S_DRAIN);
         if (r_state == S_IDLE && bus.start) begin
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
            r_fail_addr <= '0;
`ifdef SRAM_MARCH_FAULT_INJECT_EN
            r_inject    <= bus.inject;
`endif
         end else begin
            if (|w_mis) begin
               r_fail_mask <= r_fail_mask | w_mis;
               if (r_fail_mask == '0) r_fail_addr <= r_cmp_addr;
            end
            if (r_state == S_DRAIN) begin
               r_busy <= 1'b0;
               r_pass <= ((r_fail_mask | w_mis) == '0);
            end
         end
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.fail_mask = r_fail_mask;
   assign bus.fail_addr = r_fail_addr;
   assign bus.mem_men   = r_men;
   assign bus.mem_wen   = r_wen;
   assign bus.mem_ren   = r_ren;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_din   = r_din;
   assign bus.mem_bm    = '1;
endmodule

// File: tb/tb_sram_march_tester.sv
// Bench for sram_march_tester: two-bank SRAM model with stuck-at faults and a run-result scoreboard.
module tb_sram_march_tester;
   localparam int unsigned NB = 2;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned N  = 16;
   localparam int BUSY_CYC = 10 * N + 1;
   localparam logic [DW-1:0] P = 32'h5555_5555;

   typedef struct {
      logic          pass;
      logic [NB-1:0] mask;
      logic [AW-1:0] addr;
      int            busy;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   viol = 0;
   res_t sb[$];

   logic [DW-1:0] mem  [NB][N];
   logic [DW-1:0] sa0  [NB][N];
   logic [DW-1:0] sa1  [NB][N];
   logic [DW-1:0] rdata[NB];

   sram_march_if #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) bus ();

   sram_march_tester #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .BG_PATTERN(32'h5555_5555)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Single-port SRAM model with per-cell stuck-at masks and bus protocol checks.
   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (bus.mem_men && bus.mem_wen)
            mem[b][bus.mem_addr] <= (bus.mem_din & ~sa0[b][bus.mem_addr]) | sa1[b][bus.mem_addr];
         if (bus.mem_men && bus.mem_ren)
            rdata[b] <= (mem[b][bus.mem_addr] & ~sa0[b][bus.mem_addr]) | sa1[b][bus.mem_addr];
      end
      if ((bus.mem_wen && bus.mem_ren) || (bus.mem_men != (bus.mem_wen || bus.mem_ren)) ||
          (bus.mem_bm != '1))
         viol <= viol + 1;
   end

   always_comb begin
      bus.mem_dout = '0;
      for (int b = 0; b < NB; b++) bus.mem_dout[b*DW +: DW] = rdata[b];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_faults();
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < N; a++) begin
            sa0[b][a] = '0;
            sa1[b][a] = '0;
         end
   endtask

   task automatic push_exp(input logic pass, input logic [NB-1:0] mask,
                           input logic [AW-1:0] addr, input int busy);
      res_t e;
      e.pass = pass; e.mask = mask; e.addr = addr; e.busy = busy;
      sb.push_back(e);
   endtask

   // Start is sampled at the next rising edge; returns just after that edge.
   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Waits for done (bounded), counting busy cycles, then compares against the scoreboard head.
   task automatic run_and_check(input string tag, input int bc0);
      int   bc;
      bit   got;
      res_t e;
      bc  = bc0;
      got = 1'b0;
      for (int i = 0; i < BUSY_CYC + 20 && !got; i++) begin
         @(negedge clk);
         if (bus.busy) bc++;
         if (bus.done) got = 1'b1;
      end
      check({tag, "_done_seen"}, 64'(got), 64'd1);
      e = sb.pop_front();
      check({tag, "_busy_cycles"}, 64'(bc), 64'(e.busy));
      check({tag, "_pass"}, 64'(bus.pass), 64'(e.pass));
      check({tag, "_fail_mask"}, 64'(bus.fail_mask), 64'(e.mask));
      check({tag, "_fail_addr"}, 64'(bus.fail_addr), 64'(e.addr));
      check({tag, "_busy_low_at_done"}, 64'(bus.busy), 64'd0);
      check({tag, "_bus_protocol"}, 64'(viol), 64'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_status"}, 64'({bus.busy, bus.done, bus.pass, bus.fail_mask, bus.fail_addr}), 64'd0);
      check({tag, "_membus"}, 64'({bus.mem_men, bus.mem_wen, bus.mem_ren, bus.mem_addr}), 64'd0);
      check({tag, "_mem_din"}, 64'(bus.mem_din), 64'd0);
   endtask

   initial begin
      int done_seen;
      bus.start = 1'b0;
`ifdef SRAM_MARCH_FAULT_INJECT_EN
      bus.inject = 1'b0;
`endif
      clear_faults();
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_reset_idle");

      // Fault-free run
      push_exp(1'b1, 2'b00, 4'd0, BUSY_CYC);
      pulse_start();
      run_and_check("clean", 0);

      // Bank 1 bit 3 stuck-at-1 at address 5: caught by the first M1 read of P
      clear_faults();
      sa1[1][5] = 32'h0000_0008;
      push_exp(1'b0, 2'b10, 4'd5, BUSY_CYC);
      pulse_start();
      run_and_check("b1_sa1", 0);

      // Bit 0 stuck-at-0 at address 0 in both banks
      clear_faults();
      sa0[0][0] = 32'h0000_0001;
      sa0[1][0] = 32'h0000_0001;
      push_exp(1'b0, 2'b11, 4'd0, BUSY_CYC);
      pulse_start();
      run_and_check("both_sa0", 0);

      // Reset mid-M3 aborts without a done; a fresh run then passes
      clear_faults();
      pulse_start();
      done_seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      check("abort_no_done_before_rst", 64'(done_seen), 64'd0);
      check("abort_busy_before_rst", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      #1 check_idle_outputs("mid_run_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) done_seen++;
      end
      check("abort_quiet_after_rst", 64'(done_seen), 64'd0);
      push_exp(1'b1, 2'b00, 4'd0, BUSY_CYC);
      pulse_start();
      run_and_check("after_abort", 0);

      // Start held high: ignored while busy, restart right after the done cycle
      push_exp(1'b1, 2'b00, 4'd0, BUSY_CYC);
      push_exp(1'b1, 2'b00, 4'd0, BUSY_CYC);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      run_and_check("held_run1", 0);
      @(negedge clk);
      check("held_idle_gap", 64'(bus.busy), 64'd0);
      @(negedge clk);
      check("held_restart", 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      run_and_check("held_run2", 1);

`ifdef SRAM_MARCH_FAULT_INJECT_EN
      // Injected bit-0 flip at address 0 on a fault-free memory, latched at start
      bus.inject = 1'b1;
      push_exp(1'b0, 2'b11, 4'd0, BUSY_CYC);
      pulse_start();
      bus.inject = 1'b0;
      run_and_check("inject", 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sram_march_tester.md
Name: sram_march_tester

Overview:
Parametrised on-chip memory test engine that exercises NUM_BANKS single-port SRAM macros in parallel with a March C- sequence. Drives one shared command bus (enable/write/read/address/data/bit-mask) to every bank and checks each bank's read data independently. Reports per-bank pass/fail and the first failing address. Sits in chip_core between the pad-level control inputs and the SRAM macro instances, replacing tied-off macro ports with a self-checking test path.

Parameters:
NUM_BANKS, 2, number of SRAM banks tested in parallel (>=1)
ADDR_W, 10, address width; N = 2**ADDR_W words per bank
DATA_W, 32, word width
BG_PATTERN, 32'h5555_5555, background pattern P, truncated to DATA_W LSBs; ~P is its bitwise complement

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a test run; sampled only in IDLE
busy  output  1  high while a march run is in progress
done  output  1  one-cycle pulse when a run completes
pass  output  1  high after a run if no bank failed; held until next start
fail_mask  output  NUM_BANKS  bit b set if bank b had any mismatch; held until next start
fail_addr  output  ADDR_W  address of first mismatch in the run (any bank); 0 if none
mem_men  output  1  memory enable to all banks
mem_wen  output  1  write enable to all banks
mem_ren  output  1  read enable to all banks
mem_addr  output  ADDR_W  address to all banks
mem_din  output  DATA_W  write data to all banks
mem_bm  output  DATA_W  bit-write mask to all banks; constant all-ones
mem_dout  input  NUM_BANKS*DATA_W  read data, bank b in bits [b*DATA_W +: DATA_W]

Behaviour:
- Reset (async assert, deasserted synchronously to clk by upstream logic): state IDLE; busy=0, done=0, pass=0, fail_mask=0, fail_addr=0, mem_men=mem_wen=mem_ren=0, mem_addr=0, mem_din=0. Reset mid-run aborts immediately; no result reported.
- SRAM model: read issued at edge k (mem_men&mem_ren); data valid on mem_dout during cycle k+1, compared at edge k+1. mem_wen and mem_ren never both high.
- States: IDLE, M0..M5, DRAIN, DONE.
  - M0 up: write P, 1 cycle/address.
  - M1 up: read expect P, then write ~P; 2 cycles/address (read cycle, write cycle).
  - M2 up: read ~P, write P; 2 cycles/address.
  - M3 down: read P, write ~P; 2 cycles/address.
  - M4 down: read ~P, write P; 2 cycles/address.
  - M5 down: read P; 1 cycle/address.
  - DRAIN: 1 cycle, compares last M5 read; no memory access.
  - DONE: done=1 one cycle, busy=0, return to IDLE.
- Up sweeps run 0..N-1, down sweeps N-1..0; address counter wraps at element boundary without extra cycles.
- start in IDLE at edge s: fail_mask, fail_addr, pass cleared at that edge; busy=1 from cycle s+1 through DRAIN; busy high for exactly 10N+1 cycles; done high in cycle s+10N+2.
- start while busy ignored.
- Compare: per bank, mismatch of full DATA_W word sets fail_mask[b]. fail_addr captured only on the first mismatch of the run (lowest cycle); simultaneous mismatches in several banks record one address, all their mask bits set.
- pass = (fail_mask==0), updated in DONE cycle, held until next start.
- mem_men high exactly when read or write issued.

Optional Feature:
SRAM_MARCH_FAULT_INJECT_EN: when defined, adds input inject (1 bit). If inject=1 when start is accepted, every write to address 0 during that run drives mem_din with bit 0 inverted. Without the macro: no inject port, write data always P/~P.

Test Plan:
- ADDR_W=4, NUM_BANKS=2, fault-free model: pulse start -> busy high 161 cycles, done pulse, pass=1, fail_mask=2'b00, fail_addr=0.
- Bank 1 bit 3 stuck-at-1 at address 5: run -> pass=0, fail_mask=2'b10, fail_addr=5 (first detected in M1 read P).
- Stuck-at-0 bit 0 address 0 in both banks: run -> fail_mask=2'b11, fail_addr=0.
- Assert rst in mid-M3, release, start again on fault-free model -> no done during aborted run; second run pass=1 after 161 busy cycles.
- start held high throughout run -> ignored while busy; new run begins immediately after done cycle.
- With SRAM_MARCH_FAULT_INJECT_EN and inject=1, fault-free model -> pass=0, fail_mask=2'b11, fail_addr=0.
